// File: rtl/sys_cmd_master_if.sv
// Host-side command bus: request in, UART TX/RX byte links, and response out.
interface sys_cmd_master_if #(
  parameter int width = 8,
  parameter int depth = 16
);
  localparam int AW = $clog2(depth);

  logic                 Req_Valid;
  logic                 Req_Ready;
  logic [1:0]           Req_Cmd;
  logic [AW-1:0]        Req_Addr;
  logic [width-1:0]     Req_OpA;
  logic [width-1:0]     Req_OpB;
  logic [3:0]           Req_Fun;
  logic [width-1:0]     Tx_P_Data;
  logic                 Tx_Data_Valid;
  logic                 Tx_Busy;
  logic [width-1:0]     Rx_P_Data;
  logic                 Rx_Valid;
  logic [2*width-1:0]   Rsp_Data;
  logic                 Rsp_Valid;
  logic                 Rsp_Timeout;

  // Command master side (the design).
  modport master (
    input  Req_Valid, Req_Cmd, Req_Addr, Req_OpA, Req_OpB, Req_Fun,
    input  Tx_Busy, Rx_P_Data, Rx_Valid,
    output Req_Ready, Tx_P_Data, Tx_Data_Valid, Rsp_Data, Rsp_Valid, Rsp_Timeout
  );

  // Host / UART side driving the master.
  modport slave (
    output Req_Valid, Req_Cmd, Req_Addr, Req_OpA, Req_OpB, Req_Fun,
    output Tx_Busy, Rx_P_Data, Rx_Valid,
    input  Req_Ready, Tx_P_Data, Tx_Data_Valid, Rsp_Data, Rsp_Valid, Rsp_Timeout
  );
endinterface

// File: rtl/sys_cmd_master.sv
// System command master: serialises one request into a command frame on the
// UART TX byte link and assembles the optional response from the RX byte link.
module sys_cmd_master #(
  parameter int width   = 8,
  parameter int depth   = 16,
  parameter int TIMEOUT = 1024
) (
  input logic              CLK,
  input logic              Reset,
  sys_cmd_master_if.master bus
);
  localparam int AW = $clog2(depth);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, STROBE, WAIT_HI, WAIT_LO, RSP, DONE
  } state_t;

  state_t           state;
  logic [1:0]       cmd;
  logic [AW-1:0]    addr;
  logic [width-1:0] opa;
  logic [width-1:0] opb;
  logic [3:0]       fun;
  logic [1:0]       idx;
  logic             rcnt;
  logic [TW-1:0]    tcnt;
  logic [width-1:0] byte_sel;
  logic [1:0]       last_idx;

  // Frame byte at the current index and the index of the final frame byte.
  always_comb begin
    byte_sel = '0;
    last_idx = 2'd1;
    case (cmd)
      2'd0: begin
        last_idx = 2'd2;
        case (idx)
          2'd0:    byte_sel = width'(8'hAA);
          2'd1:    byte_sel = {{(width-AW){1'b0}}, addr};
          default: byte_sel = opa;
        endcase
      end
      2'd1: begin
        last_idx = 2'd1;
        if (idx == 2'd0) byte_sel = width'(8'hBB);
        else             byte_sel = {{(width-AW){1'b0}}, addr};
      end
      2'd2: begin
        last_idx = 2'd3;
        case (idx)
          2'd0:    byte_sel = width'(8'hCC);
          2'd1:    byte_sel = opa;
          2'd2:    byte_sel = opb;
          default: byte_sel = {{(width-4){1'b0}}, fun};
        endcase
      end
      default: begin
        last_idx = 2'd1;
        if (idx == 2'd0) byte_sel = width'(8'hDD);
        else             byte_sel = {{(width-4){1'b0}}, fun};
      end
    endcase
  end

  // Control FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state             <= IDLE;
      bus.Req_Ready     <= 1'b1;
      bus.Tx_P_Data     <= '0;
      bus.Tx_Data_Valid <= 1'b0;
      bus.Rsp_Data      <= '0;
      bus.Rsp_Valid     <= 1'b0;
      bus.Rsp_Timeout   <= 1'b0;
      cmd               <= '0;
      addr              <= '0;
      opa               <= '0;
      opb               <= '0;
      fun               <= '0;
      idx               <= '0;
      rcnt              <= 1'b0;
      tcnt              <= '0;
    end else begin
      bus.Tx_Data_Valid <= 1'b0;
      bus.Rsp_Valid     <= 1'b0;
      bus.Rsp_Timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Req_Valid) begin
            cmd           <= bus.Req_Cmd;
            addr          <= bus.Req_Addr;
            opa           <= bus.Req_OpA;
            opb           <= bus.Req_OpB;
            fun           <= bus.Req_Fun;
            idx           <= '0;
            bus.Rsp_Data  <= '0;
            bus.Req_Ready <= 1'b0;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (!bus.Tx_Busy) begin
            bus.Tx_P_Data     <= byte_sel;
            bus.Tx_Data_Valid <= 1'b1;
            state             <= STROBE;
          end
        end
        STROBE:  state <= WAIT_HI;
        WAIT_HI: if (bus.Tx_Busy) state <= WAIT_LO;
        WAIT_LO: begin
          if (!bus.Tx_Busy) begin
            if (idx != last_idx) begin
              idx   <= idx + 2'd1;
              state <= LOAD;
            end else if (cmd == 2'd0) begin
              bus.Rsp_Valid <= 1'b1;
              state         <= DONE;
            end else begin
              rcnt  <= 1'b0;
              tcnt  <= '0;
              state <= RSP;
            end
          end
        end
        RSP: begin
          // A byte arriving on the expiry cycle takes priority over the timeout.
          if (bus.Rx_Valid) begin
            tcnt <= '0;
            if (!rcnt) bus.Rsp_Data[width-1:0]       <= bus.Rx_P_Data;
            else       bus.Rsp_Data[2*width-1:width] <= bus.Rx_P_Data;
            if (rcnt || cmd == 2'd1) begin
              bus.Rsp_Valid <= 1'b1;
              state         <= DONE;
            end else begin
              rcnt <= 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            bus.Rsp_Timeout <= 1'b1;
            bus.Req_Ready   <= 1'b1;
            state           <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          bus.Req_Ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          bus.Req_Ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/sys_cmd_master.md
Name: sys_cmd_master

Overview:
- Host-side initiator for the system command protocol: accepts one command request and serialises it into command frame bytes toward a UART transmitter.
- For read/ALU commands, collects the response bytes from a UART receiver and returns the assembled result.
- Sits on the test/host side of the UART link, opposite the system controller. Drives its RX path and consumes its TX path.

Parameters:
- width, 8, data/byte width.
- depth, 16, register-file depth; address width is $clog2(depth).
- TIMEOUT, 1024, cycles allowed between response bytes before abort.

Ports:
- CLK  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- Req_Valid  input  1  command request present.
- Req_Ready  output  1  high in IDLE only; request accepted when Req_Valid && Req_Ready.
- Req_Cmd  input  2  0=RegWrite(0xAA), 1=RegRead(0xBB), 2=ALU w/ operands(0xCC), 3=ALU no operands(0xDD).
- Req_Addr  input  $clog2(depth)  register address (cmds 0,1).
- Req_OpA  input  width  write data (cmd 0) or operand A (cmd 2).
- Req_OpB  input  width  operand B (cmd 2).
- Req_Fun  input  4  ALU function (cmds 2,3).
- Tx_P_Data  output  width  byte to UART TX.
- Tx_Data_Valid  output  1  one-cycle byte strobe.
- Tx_Busy  input  1  UART TX busy.
- Rx_P_Data  input  width  byte from UART RX.
- Rx_Valid  input  1  one-cycle byte-valid strobe.
- Rsp_Data  output  2*width  response; RegRead in low byte, upper zero.
- Rsp_Valid  output  1  one-cycle pulse, response complete.
- Rsp_Timeout  output  1  one-cycle pulse, response aborted.

Behaviour:
- Reset: state IDLE; Req_Ready=1; Tx_P_Data=0, Tx_Data_Valid=0, Rsp_Data=0, Rsp_Valid=0, Rsp_Timeout=0; counters and captured fields cleared. Reset mid-frame abandons the frame immediately, with no further strobes.
- Acceptance: Req_Valid && Req_Ready captures all Req_* fields into internal registers. Req_Ready drops the next cycle.
- Frame bytes:
  - cmd0: AA, {0,addr}, data.
  - cmd1: BB, {0,addr}.
  - cmd2: CC, A, B, {0,fun}.
  - cmd3: DD, {0,fun}.
- FSM states: IDLE, LOAD, STROBE, WAIT_HI, WAIT_LO, RSP, DONE.
- IDLE -> LOAD on accept.
- LOAD: selects byte[idx], where idx is a 2-bit counter.
- LOAD -> STROBE when Tx_Busy=0.
- STROBE: Tx_Data_Valid=1 for exactly one cycle, Tx_P_Data holds the byte. Tx_P_Data stays stable until the next LOAD.
- WAIT_HI: waits for Tx_Busy=1.
- WAIT_LO: waits for Tx_Busy=0.
  - More bytes remain -> idx+1, LOAD.
  - Last byte, cmd0 -> DONE.
  - Otherwise -> RSP.
- Request-to-first-strobe latency with Tx_Busy low: 2 cycles (accept, LOAD, STROBE).
- RSP:
  - Expects 1 byte (cmd1) or 2 bytes (cmd2/3, LSB first) on Rx_Valid.
  - First byte -> Rsp_Data[width-1:0]; second -> Rsp_Data[2*width-1:width].
  - Timeout counter resets on entry and on each received byte, increments otherwise.
  - Counter reaching TIMEOUT-1 -> Rsp_Timeout pulse, Rsp_Data keeps its partial value, -> IDLE.
- DONE: Rsp_Valid pulse for one cycle, -> IDLE. For cmd0, Rsp_Valid signals write sent and Rsp_Data is 0.
- Rx_Valid outside RSP is ignored, with no state change.
- Rx_Valid on the same cycle as timeout expiry: the byte wins and the counter resets.
- Req_Valid while not Ready is ignored; the captured fields are not disturbed.

Test Plan:
- Register write: cmd0, addr=5, data=0x3C, Tx_Busy 10 cycles high per byte -> Tx bytes AA,05,3C with exactly 3 Tx_Data_Valid pulses; then Rsp_Valid with Rsp_Data=0.
- Register read: cmd1, addr=2; Rx returns 0x7E -> Tx AA-free frame BB,02; then Rsp_Data=0x007E and Rsp_Valid pulses once.
- ALU with operands: cmd2, A=0x10, B=0x20, fun=0; Rx 0x30,0x00 -> Tx CC,10,20,00; then Rsp_Data=0x0030.
- Timeout: cmd3, fun=2; Rx sends one byte 0x55, then silence -> Rsp_Timeout pulses TIMEOUT cycles after 0x55, Rsp_Data=0x0055, Req_Ready=1 the next cycle.
- Backpressure: Tx_Busy held high at request -> no Tx_Data_Valid until Busy falls; then strobe 1 cycle later.
- Reset mid-frame: assert Reset after the 2nd byte of cmd2 -> all outputs 0 and Req_Ready=1; after release, a new cmd1 completes normally.
